// File: rtl/add32_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : add32_share_ctrl (with leaf Adder16Bit)
// Brief    : Round-robin controller time-sharing one 16-bit ripple adder for
//            32-bit additions in two passes; optional subtract via ADD32_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================

module Adder16Bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);

    logic [16:0] w_carry;

    assign w_carry[0] = i_cin;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            assign o_sum[gi]     = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_carry[16];

endmodule

module add32_share_ctrl #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [32*NUM_REQ-1:0]  req_a_i,
    input  logic [32*NUM_REQ-1:0]  req_b_i,
`ifdef ADD32_SUB_EN
    input  logic [NUM_REQ-1:0]     req_sub_i,
`endif
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [31:0]            rsp_sum_o,
    output logic                   rsp_cout_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LO   = 2'd1;
    localparam logic [1:0] c_HI   = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    localparam logic [ID_W-1:0] c_LAST_INIT = ID_W'(NUM_REQ - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [ID_W-1:0] r_last_grant;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic            r_cin_lo;
    logic [31:0]     r_sum;
    logic            r_carry;
    logic            r_cout;

    logic [ID_W-1:0] w_grant_idx;
    logic            w_grant_found;
    logic [31:0]     w_sel_a;
    logic [31:0]     w_sel_b;
    logic            w_sel_sub;
    logic [31:0]     w_sel_b_eff;

    logic [15:0]     w_add_a;
    logic [15:0]     w_add_b;
    logic            w_add_cin;
    logic [15:0]     w_add_sum;
    logic            w_add_cout;

    // Search upward from the requester after the last grant.
    always_comb begin
        w_grant_idx   = '0;
        w_grant_found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_grant_found && req_valid_i[k] &&
                    (k == (int'(r_last_grant) + off) % NUM_REQ)) begin
                    w_grant_found = 1'b1;
                    w_grant_idx   = ID_W'(k);
                end
            end
        end
    end

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant_idx == ID_W'(k)) begin
                w_sel_a = req_a_i[32*k +: 32];
                w_sel_b = req_b_i[32*k +: 32];
`ifdef ADD32_SUB_EN
                w_sel_sub = req_sub_i[k];
`endif
            end
        end
    end

    // Subtraction is A + ~B + 1; the +1 enters as the low-pass carry-in.
    assign w_sel_b_eff = w_sel_sub ? ~w_sel_b : w_sel_b;

    always_comb begin
        req_ready_o = '0;
        if ((r_state == c_IDLE) && !rst_i && w_grant_found) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                req_ready_o[k] = (w_grant_idx == ID_W'(k));
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_grant_found) w_state_next = c_LO;
            c_LO:    w_state_next = c_HI;
            c_HI:    w_state_next = c_RESP;
            c_RESP:  if (rsp_ready_i) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_add_a   = (r_state == c_HI) ? r_a[31:16] : r_a[15:0];
    assign w_add_b   = (r_state == c_HI) ? r_b[31:16] : r_b[15:0];
    assign w_add_cin = (r_state == c_HI) ? r_carry    : r_cin_lo;

    Adder16Bit u_adder (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant <= c_LAST_INIT;
            r_id         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_cin_lo     <= 1'b0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
            r_cout       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant_found) begin
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b_eff;
                        r_cin_lo     <= w_sel_sub;
                        r_id         <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                    end
                end
                c_LO: begin
                    r_sum[15:0] <= w_add_sum;
                    r_carry     <= w_add_cout;
                end
                c_HI: begin
                    r_sum[31:16] <= w_add_sum;
                    r_cout       <= w_add_cout;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid_o = (r_state == c_RESP);
    assign rsp_id_o    = r_id;
    assign rsp_sum_o   = r_sum;
    assign rsp_cout_o  = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_add32_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_add32_share_ctrl
// Brief    : Directed and randomized self-checking bench for add32_share_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_add32_share_ctrl;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 2;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_sum;
    logic                  rsp_cout;

    int n_vec = 0;
    int n_err = 0;
    int mdl_last = NUM_REQ - 1;

    add32_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
`ifdef ADD32_SUB_EN
        .req_sub_i   (req_sub),
`endif
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_sum_o   (rsp_sum),
        .rsp_cout_o  (rsp_cout)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: {carry/no-borrow, 32-bit result}.
    function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (sub) return {(a >= b), a - b};
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic int pick(input logic [NUM_REQ-1:0] v);
        logic [NUM_REQ-1:0] tmp;
        for (int off = 1; off <= NUM_REQ; off++) begin
            int idx;
            idx = (mdl_last + off) % NUM_REQ;
            tmp = v >> idx;
            if (tmp[0]) return idx;
        end
        return -1;
    endfunction

    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input int hold);
        logic [32:0]        exp;
        logic [NUM_REQ-1:0] exp_ready;
        int                 wait_cnt;
        int                 other;
        exp   = ref_op(a, b, sub);
        other = (k + 1) % NUM_REQ;
        req_a[32*k +: 32] = a;
        req_b[32*k +: 32] = b;
        req_sub[k]   = sub;
        req_valid[k] = 1'b1;
        rsp_ready    = (hold == 0);
        #1;
        wait_cnt = 0;
        while (req_ready == '0 && wait_cnt < 16) begin
            tick();
            wait_cnt++;
        end
        exp_ready    = '0;
        exp_ready[k] = 1'b1;
        check("grant", req_ready, exp_ready);
        mdl_last = k;
        tick();
        req_valid[k] = 1'b0;
        req_a[32*k +: 32] = $urandom;
        req_b[32*k +: 32] = $urandom;
        req_sub[k] = ~sub;
        #1;
        check("lo_ready", req_ready, 0);
        check("lo_valid", rsp_valid, 0);
        tick();
        check("hi_valid", rsp_valid, 0);
        tick();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_sum", rsp_sum, exp[31:0]);
        check("rsp_cout", rsp_cout, exp[32]);
        check("rsp_id", rsp_id, k);
        if (hold > 0) begin
            req_valid[other] = 1'b1;
            #1;
            check("bp_ready", req_ready, 0);
        end
        for (int i = 1; i < hold; i++) begin
            tick();
            check("bp_valid", rsp_valid, 1);
            check("bp_sum", rsp_sum, exp[31:0]);
            check("bp_id", rsp_id, k);
            check("bp_ready", req_ready, 0);
        end
        if (hold > 0) begin
            tick();
            rsp_ready = 1'b1;
            req_valid[other] = 1'b0;
            #1;
            check("bp_last_valid", rsp_valid, 1);
            check("bp_last_sum", rsp_sum, exp[31:0]);
        end
        tick();
        check("rsp_done", rsp_valid, 0);
    endtask

    initial begin
        logic [32:0]        q_exp[$];
        int                 q_id[$];
        logic [NUM_REQ-1:0] exp_ready;
        int                 last_cyc;
        int                 grants;
        int                 g;
        int                 prev_g;
        logic [32:0]        e;
        logic               sub;

        rst_i     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_ready", req_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_sum", rsp_sum, 0);
        check("rst_cout", rsp_cout, 0);
        check("rst_id", rsp_id, 0);
        req_valid[0] = 1'b1;
        #1;
        check("rst_with_valid_ready", req_ready, 0);
        req_valid = '0;
        tick();
        rst_i = 1'b0;
        #1;

        run_op(0, 32'h0000FFFF, 32'h00000001, 1'b0, 0);
        run_op(1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
        run_op(0, $urandom, $urandom, 1'b0, 5);

        for (int n = 0; n < 12; n++) begin
            sub = 1'b0;
`ifdef ADD32_SUB_EN
            sub = 1'($urandom_range(0, 1));
`endif
            run_op(int'($urandom_range(0, NUM_REQ - 1)), $urandom, $urandom, sub, int'($urandom_range(0, 2)));
        end

`ifdef ADD32_SUB_EN
        run_op(0, 32'd5, 32'd7, 1'b1, 0);
        run_op(1, 32'd7, 32'd5, 1'b1, 0);
`endif

        // Reset while the high half is being computed.
        req_a[63:32] = 32'h12345678;
        req_b[63:32] = 32'h00000001;
        req_sub[1]   = 1'b0;
        req_valid[1] = 1'b1;
        #1;
        check("abort_grant", req_ready, 2'b10);
        tick();
        req_valid[1] = 1'b0;
        tick();
        rst_i = 1'b1;
        req_valid[0] = 1'b1;
        #1;
        check("abort_hi_ready", req_ready, 0);
        tick();
        check("abort_valid", rsp_valid, 0);
        check("abort_sum", rsp_sum, 0);
        check("abort_cout", rsp_cout, 0);
        check("abort_id", rsp_id, 0);
        check("abort_ready", req_ready, 0);
        rst_i     = 1'b0;
        req_valid = '0;
        mdl_last  = NUM_REQ - 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_rsp", rsp_valid, 0);
        end

        // Contention: every requester valid continuously from reset.
        rst_i     = 1'b1;
        req_valid = '1;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_a[32*k +: 32] = $urandom;
            req_b[32*k +: 32] = $urandom;
        end
        req_sub   = '0;
        rsp_ready = 1'b1;
        tick();
        rst_i    = 1'b0;
        mdl_last = NUM_REQ - 1;
        last_cyc = -1;
        grants   = 0;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            prev_g = -1;
            if (rsp_valid === 1'b1) begin
                if (q_exp.size() == 0) begin
                    check("rr_unexpected_rsp", rsp_valid, 0);
                end else begin
                    e = q_exp.pop_front();
                    check("rr_sum", rsp_sum, e[31:0]);
                    check("rr_cout", rsp_cout, e[32]);
                    check("rr_id", rsp_id, q_id.pop_front());
                end
            end
            if (req_ready != '0) begin
                g = pick(req_valid);
                exp_ready = '0;
                if (g >= 0) exp_ready[g] = 1'b1;
                check("rr_grant", req_ready, exp_ready);
                if (last_cyc >= 0) check("rr_interval", cyc - last_cyc, 4);
                last_cyc = cyc;
                if (g >= 0) begin
                    mdl_last = g;
                    q_exp.push_back(ref_op(req_a[32*g +: 32], req_b[32*g +: 32], 1'b0));
                    q_id.push_back(g);
                    prev_g = g;
                end
                grants++;
            end
            tick();
            if (prev_g >= 0) begin
                req_a[32*prev_g +: 32] = $urandom;
                req_b[32*prev_g +: 32] = $urandom;
            end
            #1;
        end
        check("rr_grant_count", grants, 10);
        check("rr_all_responded", q_exp.size(), 0);
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/add32_share_ctrl.md
# add32_share_ctrl

Controller that time-shares one 16-bit ripple adder (`Adder16Bit`) among several requesters to perform 32-bit additions in two passes: low half, then high half with carry. It arbitrates round-robin between requesters, sequences both adder passes, and returns the result on a single tagged response port with backpressure. It sits between MAC accumulation front-ends and the shared adder datapath in the FPGA MAC.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..4.
- ID_W, 2: width of the response tag; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk_i  in  1  single clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept strobe; one-hot or zero.
- req_a_i  in  32*NUM_REQ  operand A; requester k occupies bits [32k+31:32k].
- req_b_i  in  32*NUM_REQ  operand B, same packing.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  consumer accepts the result.
- rsp_id_o  out  ID_W  index of the requester that owns the result.
- rsp_sum_o  out  32  result.
- rsp_cout_o  out  1  carry out of bit 31.

## Operation
- The block instantiates one `Adder16Bit` and drives it with muxed halves of the captured operands.
- FSM states: IDLE, LO, HI, RESP.
- IDLE: if any req_valid_i is high, grant the first valid requester searching upward from (last_grant+1) mod NUM_REQ. Drive req_ready_o[grant]=1 combinationally in the same cycle. On the clock edge, capture A, B and the ID, update last_grant, and go to LO. If no request is valid, remain in IDLE and keep req_ready_o at 0.
- LO: adder computes A[15:0]+B[15:0]+cin_lo, where cin_lo=0. Register sum[15:0] and carry_reg, then go to HI.
- HI: adder computes A[31:16]+B[31:16]+carry_reg. Register sum[31:16] and cout, then go to RESP.
- RESP: assert rsp_valid_o. rsp_sum_o, rsp_cout_o and rsp_id_o hold stable until rsp_ready_i=1. The transfer occurs on the cycle where rsp_valid_o and rsp_ready_i are both high; the FSM then goes to IDLE.
- Arithmetic is modulo 2^32. rsp_cout_o is the true bit 32 of the sum.
- Requesters must hold valid and operands stable until they see ready. Operands are sampled only on the grant edge; changes after the grant have no effect.
- Only one operation is in flight at a time. req_ready_o is 0 in LO, HI and RESP.

## Timing
- Reset values: state=IDLE, req_ready_o=0, rsp_valid_o=0, rsp_sum_o=0, rsp_cout_o=0, rsp_id_o=0. last_grant=NUM_REQ-1, so requester 0 has first priority.
- Latency: a handshake in cycle t gives rsp_valid_o=1 in cycle t+3.
- Peak throughput is one operation per 4 cycles, with the response accepted in its first valid cycle.
- Backpressure: RESP holds indefinitely while rsp_ready_i=0, and no new grant is issued during that time.
- rst_i asserted in any state returns the block to IDLE on the next edge. An in-flight result is discarded: rsp_valid_o drops and nothing is granted that cycle.
- Simultaneous requests: exactly one is granted per IDLE cycle. A requester waiting behind others is served within NUM_REQ operations.
- If rst_i and req_valid_i are high in the same cycle, req_ready_o is 0.

## Configuration
- ADD32_SUB_EN defined:
  - Adds port req_sub_i (in, NUM_REQ), sampled at grant.
  - When sub=1, B is bitwise inverted at capture and cin_lo=1, so the result is A-B modulo 2^32.
  - rsp_cout_o=1 means no borrow (A>=B unsigned).
- ADD32_SUB_EN undefined: the req_sub_i port is absent, and the block performs addition only with cin_lo=0.

## Test plan
- Single add: requester 0 sends A=0x0000FFFF, B=0x00000001 with rsp_ready_i=1. Expect rsp_valid_o at t+3 with sum=0x00010000, cout=0, id=0; this checks carry across the halves.
- Overflow: A=0xFFFFFFFF, B=0x00000001. Expect sum=0x00000000, cout=1.
- Round-robin: requesters 0 and 1 both valid continuously from reset. Expect grants in the order 0,1,0,1, each response tagged with the matching id, and one grant every 4 cycles.
- Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP. Expect rsp_sum_o and rsp_id_o stable, req_ready_o all zero, and return to IDLE on the cycle after rsp_ready_i=1.
- Reset mid-op: assert rst_i during HI. Expect rsp_valid_o=0 with every output at its reset value on the next cycle, and no response ever emitted for the aborted operation.
- With ADD32_SUB_EN: sub=1, A=5, B=7. Expect sum=0xFFFFFFFE, cout=0. A second case, A=7, B=5, must return sum=2, cout=1.
